// File: rtl/rv64g_l2_line_seq_if.sv
// rtl/rv64g_l2_line_seq_if.sv - request, beat-stream and array-port bundle for the L2 line sequencer
interface rv64g_l2_line_seq_if #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 50,
  parameter int IDX_W  = 8,
  parameter int WAY_W  = 4
);
  logic              fill_req_v_i;
  logic              fill_req_rdy_o;
  logic [IDX_W-1:0]  fill_idx_i;
  logic [WAY_W-1:0]  fill_way_i;
  logic [TAG_W-1:0]  fill_tag_i;
  logic              fill_beat_v_i;
  logic              fill_beat_rdy_o;
  logic [DATA_W-1:0] fill_wdata_i;
  logic              fill_done_o;
  logic              wb_req_v_i;
  logic              wb_req_rdy_o;
  logic [IDX_W-1:0]  wb_idx_i;
  logic [WAY_W-1:0]  wb_way_i;
  logic [TAG_W-1:0]  wb_tag_o;
  logic              wb_beat_v_o;
  logic              wb_beat_rdy_i;
  logic [DATA_W-1:0] wb_rdata_o;
  logic              wb_done_o;
  logic [IDX_W-1:0]  arr_index_o;
  logic [2:0]        arr_word_o;
  logic [WAY_W-1:0]  arr_way_o;
  logic              arr_data_we_o;
  logic              arr_tag_we_o;
  logic [7:0]        arr_be_o;
  logic [TAG_W-1:0]  arr_tag_o;
  logic [DATA_W-1:0] arr_wdata_o;
  logic [DATA_W-1:0] arr_rdata_i;
  logic [TAG_W-1:0]  arr_tag_i;

  // The sequencer is the master: it owns the array ports and the request/beat handshakes.
  modport master (
    input  fill_req_v_i, fill_idx_i, fill_way_i, fill_tag_i, fill_beat_v_i, fill_wdata_i,
    input  wb_req_v_i, wb_idx_i, wb_way_i, wb_beat_rdy_i, arr_rdata_i, arr_tag_i,
    output fill_req_rdy_o, fill_beat_rdy_o, fill_done_o,
    output wb_req_rdy_o, wb_tag_o, wb_beat_v_o, wb_rdata_o, wb_done_o,
    output arr_index_o, arr_word_o, arr_way_o, arr_data_we_o, arr_tag_we_o,
    output arr_be_o, arr_tag_o, arr_wdata_o
  );

  modport slave (
    output fill_req_v_i, fill_idx_i, fill_way_i, fill_tag_i, fill_beat_v_i, fill_wdata_i,
    output wb_req_v_i, wb_idx_i, wb_way_i, wb_beat_rdy_i, arr_rdata_i, arr_tag_i,
    input  fill_req_rdy_o, fill_beat_rdy_o, fill_done_o,
    input  wb_req_rdy_o, wb_tag_o, wb_beat_v_o, wb_rdata_o, wb_done_o,
    input  arr_index_o, arr_word_o, arr_way_o, arr_data_we_o, arr_tag_we_o,
    input  arr_be_o, arr_tag_o, arr_wdata_o
  );
endinterface

// File: rtl/rv64g_l2_line_seq.sv
// rtl/rv64g_l2_line_seq.sv - round-robin refill/writeback line-burst sequencer for the L2 arrays
module rv64g_l2_line_seq #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 50,
  parameter int IDX_W  = 8,
  parameter int WAY_W  = 4,
  parameter int WORDS  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  rv64g_l2_line_seq_if.master  bus
);
  localparam int WCNT_W = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, FILL, WB} state_t;

  state_t            state;
  logic [WCNT_W-1:0] word_cnt;
  logic              rr_ptr;
  logic [IDX_W-1:0]  lat_idx;
  logic [WAY_W-1:0]  lat_way;
  logic [TAG_W-1:0]  lat_tag;
  logic [TAG_W-1:0]  wb_tag_q;
  logic              fill_done_q;
  logic              wb_done_q;

  logic in_idle, in_fill, in_wb;
  logic fill_grant, wb_grant;
  logic last_word, fill_beat_fire, wb_beat_fire;

  assign in_idle   = (state == IDLE);
  assign in_fill   = (state == FILL);
  assign in_wb     = (state == WB);
  assign last_word = (word_cnt == WCNT_W'(WORDS - 1));

  // rr_ptr=0 favours fill on a tie, rr_ptr=1 favours writeback.
  assign fill_grant = in_idle & bus.fill_req_v_i & (~bus.wb_req_v_i | ~rr_ptr);
  assign wb_grant   = in_idle & bus.wb_req_v_i & (~bus.fill_req_v_i | rr_ptr);

  // Writes are suppressed on a reset cycle so an aborted fill stops at the last completed word.
  assign fill_beat_fire = in_fill & bus.fill_beat_v_i & ~rst_i;
  assign wb_beat_fire   = in_wb & bus.wb_beat_rdy_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      word_cnt    <= '0;
      rr_ptr      <= 1'b0;
      lat_idx     <= '0;
      lat_way     <= '0;
      lat_tag     <= '0;
      wb_tag_q    <= '0;
      fill_done_q <= 1'b0;
      wb_done_q   <= 1'b0;
    end else begin
      fill_done_q <= 1'b0;
      wb_done_q   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fill_grant) begin
            lat_idx  <= bus.fill_idx_i;
            lat_way  <= bus.fill_way_i;
            lat_tag  <= bus.fill_tag_i;
            word_cnt <= '0;
            rr_ptr   <= 1'b1;
            state    <= FILL;
          end else if (wb_grant) begin
            lat_idx  <= bus.wb_idx_i;
            lat_way  <= bus.wb_way_i;
            wb_tag_q <= bus.arr_tag_i;
            word_cnt <= '0;
            rr_ptr   <= 1'b0;
            state    <= WB;
          end
        end
        FILL: begin
          if (fill_beat_fire) begin
            word_cnt <= word_cnt + 1'b1;
            if (last_word) begin
              state       <= IDLE;
              fill_done_q <= 1'b1;
            end
          end
        end
        WB: begin
          if (wb_beat_fire) begin
            word_cnt <= word_cnt + 1'b1;
            if (last_word) begin
              state     <= IDLE;
              wb_done_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // In IDLE the array address follows the pending writeback so its tag can be captured on accept.
  assign bus.arr_index_o     = in_idle ? bus.wb_idx_i : lat_idx;
  assign bus.arr_way_o       = in_idle ? bus.wb_way_i : lat_way;
  assign bus.arr_word_o      = word_cnt;
  assign bus.arr_data_we_o   = fill_beat_fire;
  assign bus.arr_tag_we_o    = fill_beat_fire & last_word;
  assign bus.arr_be_o        = 8'hFF;
  assign bus.arr_tag_o       = in_fill ? lat_tag : '0;
  assign bus.arr_wdata_o     = in_fill ? bus.fill_wdata_i : '0;

  assign bus.fill_req_rdy_o  = fill_grant;
  assign bus.fill_beat_rdy_o = in_fill;
  assign bus.fill_done_o     = fill_done_q;
  assign bus.wb_req_rdy_o    = wb_grant;
  assign bus.wb_tag_o        = wb_tag_q;
  assign bus.wb_beat_v_o     = in_wb;
  assign bus.wb_rdata_o      = in_wb ? bus.arr_rdata_i : '0;
  assign bus.wb_done_o       = wb_done_q;
endmodule

// File: tb/tb_rv64g_l2_line_seq.sv
// tb/tb_rv64g_l2_line_seq.sv - self-checking bench for the L2 line-burst sequencer
module tb_rv64g_l2_line_seq;
  localparam int DATA_W = 64;
  localparam int TAG_W  = 50;
  localparam int IDX_W  = 8;
  localparam int WAY_W  = 4;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  rv64g_l2_line_seq_if #(.DATA_W(DATA_W), .TAG_W(TAG_W), .IDX_W(IDX_W), .WAY_W(WAY_W)) bus ();

  rv64g_l2_line_seq #(.DATA_W(DATA_W), .TAG_W(TAG_W), .IDX_W(IDX_W), .WAY_W(WAY_W), .WORDS(8)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // Behavioural array: combinational read, write on the rising edge.
  logic [DATA_W-1:0] mem     [0:32767];
  logic [TAG_W-1:0]  tag_mem [0:4095];
  assign bus.arr_rdata_i = mem[{bus.arr_index_o, bus.arr_way_o, bus.arr_word_o}];
  assign bus.arr_tag_i   = tag_mem[{bus.arr_index_o, bus.arr_way_o}];
  always @(posedge clk_i) begin
    if (bus.arr_data_we_o) mem[{bus.arr_index_o, bus.arr_way_o, bus.arr_word_o}] <= bus.arr_wdata_o;
    if (bus.arr_tag_we_o)  tag_mem[{bus.arr_index_o, bus.arr_way_o}] <= bus.arr_tag_o;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  typedef struct packed { logic [14:0] key; logic [63:0] data; } wr_t;
  typedef struct packed { logic [11:0] key; logic [49:0] tag; } tg_t;
  typedef struct { bit fv; bit wv; bit ef; bit ew; } arb_vec_t;

  wr_t         exp_wr [$];
  tg_t         exp_tag[$];
  logic [63:0] exp_rd [$];
  int fill_done_cnt = 0, wb_done_cnt = 0, we_cnt = 0;
  int exp_fill_done = 0, exp_wb_done = 0;

  // Scoreboard: array writes, tag writes and victim beats are popped as the DUT produces them.
  always @(negedge clk_i) begin : mon
    wr_t w;
    tg_t t;
    logic [63:0] r;
    if (bus.arr_data_we_o) begin
      we_cnt++;
      if (exp_wr.size() == 0) chk("unexpected_data_we", 1, 0);
      else begin
        w = exp_wr.pop_front();
        chk("wr_addr", {49'd0, bus.arr_index_o, bus.arr_way_o, bus.arr_word_o}, {49'd0, w.key});
        chk("wr_data", bus.arr_wdata_o, w.data);
      end
    end
    if (bus.arr_tag_we_o) begin
      if (exp_tag.size() == 0) chk("unexpected_tag_we", 1, 0);
      else begin
        t = exp_tag.pop_front();
        chk("tag_addr", {52'd0, bus.arr_index_o, bus.arr_way_o}, {52'd0, t.key});
        chk("tag_data", {14'd0, bus.arr_tag_o}, {14'd0, t.tag});
      end
    end
    if (bus.wb_beat_v_o && bus.wb_beat_rdy_i) begin
      if (exp_rd.size() == 0) chk("unexpected_wb_beat", 1, 0);
      else begin
        r = exp_rd.pop_front();
        chk("wb_rdata", bus.wb_rdata_o, r);
      end
    end
    if (bus.fill_done_o) fill_done_cnt++;
    if (bus.wb_done_o)   wb_done_cnt++;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fill_req(input logic [7:0] idx, input logic [3:0] way, input logic [49:0] tag);
    int n = 0;
    bus.fill_req_v_i = 1'b1;
    bus.fill_idx_i   = idx;
    bus.fill_way_i   = way;
    bus.fill_tag_i   = tag;
    @(negedge clk_i);
    while (!bus.fill_req_rdy_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("fill_req_grant", bus.fill_req_rdy_o, 1);
    tick();
    bus.fill_req_v_i = 1'b0;
  endtask

  task automatic wb_req(input logic [7:0] idx, input logic [3:0] way);
    int n = 0;
    bus.wb_req_v_i = 1'b1;
    bus.wb_idx_i   = idx;
    bus.wb_way_i   = way;
    @(negedge clk_i);
    while (!bus.wb_req_rdy_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("wb_req_grant", bus.wb_req_rdy_o, 1);
    tick();
    bus.wb_req_v_i = 1'b0;
  endtask

  // Drives 8 beats; gaps[k] inserts one idle cycle before beat k. Returns at the start of the done cycle.
  task automatic fill_beats(input logic [7:0] idx, input logic [3:0] way, input logic [49:0] tag,
                            input logic [63:0] base, input logic [7:0] gaps, output int cyc);
    wr_t w;
    tg_t t;
    logic [2:0] kw;
    cyc = 0;
    for (int k = 0; k < 8; k++) begin
      kw = k[2:0];
      if (gaps[k]) begin
        bus.fill_beat_v_i = 1'b0;
        @(negedge clk_i);
        chk("gap_no_we", bus.arr_data_we_o, 0);
        chk("gap_word_hold", bus.arr_word_o, kw);
        tick();
        cyc++;
      end
      bus.fill_beat_v_i = 1'b1;
      bus.fill_wdata_i  = base + 64'(k);
      w.key = {idx, way, kw};
      w.data = base + 64'(k);
      exp_wr.push_back(w);
      if (k == 7) begin
        t.key = {idx, way};
        t.tag = tag;
        exp_tag.push_back(t);
      end
      tick();
      cyc++;
    end
    bus.fill_beat_v_i = 1'b0;
  endtask

  task automatic wb_beats(input logic [63:0] base, input bit toggle);
    int n = 0;
    int acc = 0;
    for (int k = 0; k < 8; k++) exp_rd.push_back(base + 64'(k));
    while (acc < 8 && n < 40) begin
      bus.wb_beat_rdy_i = toggle ? (n % 2 == 0) : 1'b1;
      @(negedge clk_i);
      if (!bus.wb_beat_rdy_i && exp_rd.size() != 0) begin
        chk("wb_hold_v", bus.wb_beat_v_o, 1);
        chk("wb_hold_data", bus.wb_rdata_o, exp_rd[0]);
      end
      if (bus.wb_beat_rdy_i && bus.wb_beat_v_o) acc++;
      tick();
      n++;
    end
    bus.wb_beat_rdy_i = 1'b0;
    chk("wb_beats_complete", acc, 8);
  endtask

  task automatic expect_done(input bit is_fill);
    @(negedge clk_i);
    if (is_fill) begin
      chk("fill_done_pulse", bus.fill_done_o, 1);
      exp_fill_done++;
    end else begin
      chk("wb_done_pulse", bus.wb_done_o, 1);
      exp_wb_done++;
    end
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    arb_vec_t tbl [13];
    wr_t w;
    int cyc;
    int we0;
    tbl[0]  = '{1, 1, 1, 0};
    tbl[1]  = '{1, 1, 0, 1};
    tbl[2]  = '{1, 1, 1, 0};
    tbl[3]  = '{1, 1, 0, 1};
    tbl[4]  = '{1, 1, 1, 0};
    tbl[5]  = '{1, 1, 0, 1};
    tbl[6]  = '{1, 1, 1, 0};
    tbl[7]  = '{1, 1, 0, 1};
    tbl[8]  = '{0, 1, 0, 1};
    tbl[9]  = '{1, 0, 1, 0};
    tbl[10] = '{1, 0, 1, 0};
    tbl[11] = '{1, 1, 0, 1};
    tbl[12] = '{0, 0, 0, 0};

    for (int i = 0; i < 32768; i++) mem[i] = '0;
    for (int i = 0; i < 4096; i++) tag_mem[i] = '0;
    rst_i = 1'b1;
    bus.fill_req_v_i = 0; bus.fill_idx_i = 0; bus.fill_way_i = 0; bus.fill_tag_i = 0;
    bus.fill_beat_v_i = 0; bus.fill_wdata_i = 0;
    bus.wb_req_v_i = 0; bus.wb_idx_i = 8'h77; bus.wb_way_i = 4'h9; bus.wb_beat_rdy_i = 0;
    repeat (3) tick();
    rst_i = 1'b0;

    @(negedge clk_i);
    chk("rst_fill_req_rdy", bus.fill_req_rdy_o, 0);
    chk("rst_wb_req_rdy", bus.wb_req_rdy_o, 0);
    chk("rst_fill_beat_rdy", bus.fill_beat_rdy_o, 0);
    chk("rst_wb_beat_v", bus.wb_beat_v_o, 0);
    chk("rst_data_we", bus.arr_data_we_o, 0);
    chk("rst_tag_we", bus.arr_tag_we_o, 0);
    chk("rst_be", bus.arr_be_o, 8'hFF);
    chk("rst_word", bus.arr_word_o, 0);
    chk("rst_index_follows_wb", bus.arr_index_o, 8'h77);
    chk("rst_way_follows_wb", bus.arr_way_o, 4'h9);
    chk("rst_wb_tag", bus.wb_tag_o, 0);
    chk("rst_dones", {bus.fill_done_o, bus.wb_done_o}, 0);
    chk("rst_wdata_tag", {bus.arr_wdata_o[13:0], bus.arr_tag_o}, 0);
    tick();

    // Back-to-back line fill.
    fill_req(8'h2A, 4'h5, 50'h1234);
    fill_beats(8'h2A, 4'h5, 50'h1234, 64'h100, 8'h00, cyc);
    chk("fill_cycles", cyc, 8);
    expect_done(1);

    // Gaps after beats 2 and 5.
    we0 = we_cnt;
    fill_req(8'h2B, 4'h6, 50'h777);
    fill_beats(8'h2B, 4'h6, 50'h777, 64'h200, 8'b0100_1000, cyc);
    chk("gap_fill_cycles", cyc, 10);
    expect_done(1);
    chk("gap_fill_we_pulses", we_cnt - we0, 8);

    // Writeback of the first line under alternating backpressure.
    wb_req(8'h2A, 4'h5);
    wb_beats(64'h100, 1'b1);
    expect_done(0);
    chk("wb_tag_captured", bus.wb_tag_o, 50'h1234);

    // Arbitration table: both valid at reset exit, then strict alternation and single-requester cases.
    rst_i = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 13; i++) begin
      bus.fill_req_v_i = tbl[i].fv;
      bus.fill_idx_i   = 8'(8'h40 + i);
      bus.fill_way_i   = 4'h3;
      bus.fill_tag_i   = 50'(50'h500 + i);
      bus.wb_req_v_i   = tbl[i].wv;
      bus.wb_idx_i     = 8'h2A;
      bus.wb_way_i     = 4'h5;
      rst_i = 1'b0;
      @(negedge clk_i);
      chk($sformatf("arb%0d_fill_rdy", i), bus.fill_req_rdy_o, tbl[i].ef);
      chk($sformatf("arb%0d_wb_rdy", i), bus.wb_req_rdy_o, tbl[i].ew);
      tick();
      bus.fill_req_v_i = 1'b0;
      bus.wb_req_v_i   = 1'b0;
      if (tbl[i].ef) begin
        fill_beats(8'(8'h40 + i), 4'h3, 50'(50'h500 + i), 64'h1000 * 64'(i + 1), 8'h00, cyc);
        expect_done(1);
      end
      if (tbl[i].ew) begin
        wb_beats(64'h100, 1'b0);
        expect_done(0);
        chk("arb_wb_tag", bus.wb_tag_o, 50'h1234);
      end
    end

    // Reset while beat 3 is presented.
    fill_req(8'h33, 4'h2, 50'hABC);
    for (int k = 0; k < 3; k++) begin
      bus.fill_beat_v_i = 1'b1;
      bus.fill_wdata_i  = 64'h300 + 64'(k);
      w.key = {8'h33, 4'h2, 3'(k)};
      w.data = 64'h300 + 64'(k);
      exp_wr.push_back(w);
      tick();
    end
    bus.fill_wdata_i = 64'h303;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    bus.fill_beat_v_i = 1'b0;
    @(negedge clk_i);
    chk("abort_idle_beat_rdy", bus.fill_beat_rdy_o, 0);
    chk("abort_no_we", bus.arr_data_we_o, 0);
    chk("abort_no_done", bus.fill_done_o, 0);
    tick();
    chk("abort_word2_written", mem[{8'h33, 4'h2, 3'd2}], 64'h302);
    chk("abort_word3_untouched", mem[{8'h33, 4'h2, 3'd3}], 0);
    chk("abort_tag_untouched", tag_mem[{8'h33, 4'h2}], 0);

    // New fill presented during the done cycle is accepted there.
    fill_req(8'h50, 4'h7, 50'h55);
    fill_beats(8'h50, 4'h7, 50'h55, 64'h600, 8'h00, cyc);
    bus.fill_req_v_i = 1'b1;
    bus.fill_idx_i   = 8'h51;
    bus.fill_way_i   = 4'h8;
    bus.fill_tag_i   = 50'h66;
    @(negedge clk_i);
    chk("b2b_done", bus.fill_done_o, 1);
    chk("b2b_rdy_in_done", bus.fill_req_rdy_o, 1);
    exp_fill_done++;
    tick();
    bus.fill_req_v_i = 1'b0;
    @(negedge clk_i);
    chk("b2b_busy_no_rdy", bus.fill_req_rdy_o, 0);
    chk("b2b_fill_active", bus.fill_beat_rdy_o, 1);
    tick();
    fill_beats(8'h51, 4'h8, 50'h66, 64'h700, 8'h00, cyc);
    expect_done(1);
    @(negedge clk_i);
    chk("b2b_no_dup_grant", bus.fill_beat_rdy_o, 0);
    tick();

    chk("sb_writes_drained", exp_wr.size(), 0);
    chk("sb_tags_drained", exp_tag.size(), 0);
    chk("sb_reads_drained", exp_rd.size(), 0);
    chk("fill_done_count", fill_done_cnt, exp_fill_done);
    chk("wb_done_count", wb_done_cnt, exp_wb_done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
